// File: rtl/control_unit.sv
// Hardwired Mini SRC control sequencer: fetch F0-F3, execute E0-E5, HALT.
// Define MUL_DIV_EN to enable the mul/div execute sequence; otherwise those opcodes run as nop.
module control_unit (
   input  logic        Clock,
   input  logic        Clear,
   input  logic [31:0] IR,
   input  logic        ConFF_Out,
   input  logic        Stop,
   output logic        Run,
   output logic [4:0]  CONTROL,
   output logic        PC_Out,
   output logic        MDR_Out,
   output logic        ZHI_Out,
   output logic        ZLO_Out,
   output logic        HI_Out,
   output logic        LO_Out,
   output logic        C_Out,
   output logic        InPort_Out,
   output logic        R_Out,
   output logic        BA_Out,
   output logic        PC_In,
   output logic        MDR_In,
   output logic        MAR_In,
   output logic        IR_In,
   output logic        Y_In,
   output logic        ZHI_In,
   output logic        ZLO_In,
   output logic        HI_In,
   output logic        LO_In,
   output logic        OutPort_In,
   output logic        Con_In,
   output logic        R_In,
   output logic        G_RA,
   output logic        G_RB,
   output logic        G_RC,
   output logic        IncPC,
   output logic        Read,
   output logic        Write
);

   typedef enum logic [3:0] {
      S_F0, S_F1, S_F2, S_F3, S_E0, S_E1, S_E2, S_E3, S_E4, S_E5, S_HALT
   } state_t;

   typedef enum logic [3:0] {
      C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_UNARY, C_MULDIV, C_BR,
      C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
   } class_t;

   state_t      state_q, state_d;
   logic        active_q;
   class_t      cls;
   logic [4:0]  opcode;
   logic [4:0]  imm_ctl;
   logic        unused_ir;

   assign opcode    = IR[31:27];
   assign unused_ir = ^IR[26:0];

   always_comb begin
      cls = C_NOP;
      case (opcode)
         5'd0:  cls = C_LD;
         5'd1:  cls = C_LDI;
         5'd2:  cls = C_ST;
         5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: cls = C_ALU;
         5'd12, 5'd13, 5'd14: cls = C_IMM;
`ifdef MUL_DIV_EN
         5'd15, 5'd16: cls = C_MULDIV;
`else
         5'd15, 5'd16: cls = C_NOP;
`endif
         5'd17, 5'd18: cls = C_UNARY;
         5'd19: cls = C_BR;
         5'd20: cls = C_JR;
         5'd22: cls = C_IN;
         5'd23: cls = C_OUT;
         5'd24: cls = C_MFHI;
         5'd25: cls = C_MFLO;
         5'd27: cls = C_HALT;
         default: cls = C_NOP;
      endcase
   end

   always_comb begin
      case (opcode)
         5'd12:   imm_ctl = 5'b00011;
         5'd13:   imm_ctl = 5'b00101;
         default: imm_ctl = 5'b00110;
      endcase
   end

   // active_q keeps F0 silent during reset and until the first edge after Clear rises.
   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         state_q  <= S_F0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         active_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = S_F0;
      case (state_q)
         S_F0: state_d = (active_q && !Stop) ? S_F1 : S_F0;
         S_F1: state_d = S_F2;
         S_F2: state_d = S_F3;
         S_F3: state_d = S_E0;
         S_E0: begin
            case (cls)
               C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP: state_d = S_F0;
               C_HALT:  state_d = S_HALT;
               default: state_d = S_E1;
            endcase
         end
         S_E1: state_d = (cls == C_UNARY) ? S_F0 : S_E2;
         S_E2: begin
            case (cls)
               C_LD, C_ST, C_MULDIV, C_BR: state_d = S_E3;
               default:                    state_d = S_F0;
            endcase
         end
         S_E3: state_d = (cls == C_LD || cls == C_ST) ? S_E4 : S_F0;
         S_E4: state_d = (cls == C_LD) ? S_E5 : S_F0;
         S_E5: state_d = S_F0;
         S_HALT: state_d = S_HALT;
         default: state_d = S_F0;
      endcase
   end

   always_comb begin
      Run        = active_q && (state_q != S_HALT) && !(state_q == S_F0 && Stop);
      CONTROL    = '0;
      PC_Out     = 1'b0;
      MDR_Out    = 1'b0;
      ZHI_Out    = 1'b0;
      ZLO_Out    = 1'b0;
      HI_Out     = 1'b0;
      LO_Out     = 1'b0;
      C_Out      = 1'b0;
      InPort_Out = 1'b0;
      R_Out      = 1'b0;
      BA_Out     = 1'b0;
      PC_In      = 1'b0;
      MDR_In     = 1'b0;
      MAR_In     = 1'b0;
      IR_In      = 1'b0;
      Y_In       = 1'b0;
      ZHI_In     = 1'b0;
      ZLO_In     = 1'b0;
      HI_In      = 1'b0;
      LO_In      = 1'b0;
      OutPort_In = 1'b0;
      Con_In     = 1'b0;
      R_In       = 1'b0;
      G_RA       = 1'b0;
      G_RB       = 1'b0;
      G_RC       = 1'b0;
      IncPC      = 1'b0;
      Read       = 1'b0;
      Write      = 1'b0;
      case (state_q)
         S_F0: if (active_q && !Stop) begin
            PC_Out = 1'b1; MAR_In = 1'b1; IncPC = 1'b1;
         end
         S_F1: Read = 1'b1;
         S_F2: begin Read = 1'b1; MDR_In = 1'b1; end
         S_F3: begin MDR_Out = 1'b1; IR_In = 1'b1; end
         S_E0: begin
            case (cls)
               C_ALU, C_IMM:       begin G_RB = 1'b1; R_Out = 1'b1; Y_In = 1'b1; end
               C_LDI, C_LD, C_ST:  begin G_RB = 1'b1; BA_Out = 1'b1; Y_In = 1'b1; end
               C_UNARY: begin G_RB = 1'b1; R_Out = 1'b1; CONTROL = opcode; ZLO_In = 1'b1; end
               C_MULDIV: begin G_RA = 1'b1; R_Out = 1'b1; Y_In = 1'b1; end
               C_BR:    begin G_RA = 1'b1; R_Out = 1'b1; Con_In = 1'b1; end
               C_JR:    begin G_RA = 1'b1; R_Out = 1'b1; PC_In = 1'b1; end
               C_IN:    begin InPort_Out = 1'b1; G_RA = 1'b1; R_In = 1'b1; end
               C_OUT:   begin G_RA = 1'b1; R_Out = 1'b1; OutPort_In = 1'b1; end
               C_MFHI:  begin HI_Out = 1'b1; G_RA = 1'b1; R_In = 1'b1; end
               C_MFLO:  begin LO_Out = 1'b1; G_RA = 1'b1; R_In = 1'b1; end
               default: ;
            endcase
         end
         S_E1: begin
            case (cls)
               C_ALU:   begin G_RC = 1'b1; R_Out = 1'b1; CONTROL = opcode; ZLO_In = 1'b1; end
               C_IMM:   begin C_Out = 1'b1; ZLO_In = 1'b1; CONTROL = imm_ctl; end
               C_LDI, C_LD, C_ST: begin C_Out = 1'b1; CONTROL = 5'b00011; ZLO_In = 1'b1; end
               C_UNARY: begin ZLO_Out = 1'b1; G_RA = 1'b1; R_In = 1'b1; end
               C_MULDIV: begin
                  G_RB = 1'b1; R_Out = 1'b1; CONTROL = opcode; ZHI_In = 1'b1; ZLO_In = 1'b1;
               end
               C_BR:    begin PC_Out = 1'b1; Y_In = 1'b1; end
               default: ;
            endcase
         end
         S_E2: begin
            case (cls)
               C_ALU, C_IMM, C_LDI: begin ZLO_Out = 1'b1; G_RA = 1'b1; R_In = 1'b1; end
               C_LD, C_ST: begin ZLO_Out = 1'b1; MAR_In = 1'b1; end
               C_MULDIV:   begin ZLO_Out = 1'b1; LO_In = 1'b1; end
               C_BR:       begin C_Out = 1'b1; CONTROL = 5'b00011; ZLO_In = 1'b1; end
               default: ;
            endcase
         end
         S_E3: begin
            case (cls)
               C_LD:     Read = 1'b1;
               C_ST:     begin G_RA = 1'b1; R_Out = 1'b1; MDR_In = 1'b1; end
               C_MULDIV: begin ZHI_Out = 1'b1; HI_In = 1'b1; end
               C_BR:     begin ZLO_Out = 1'b1; PC_In = ConFF_Out; end
               default: ;
            endcase
         end
         S_E4: begin
            case (cls)
               C_LD:    begin Read = 1'b1; MDR_In = 1'b1; end
               C_ST:    Write = 1'b1;
               default: ;
            endcase
         end
         S_E5: if (cls == C_LD) begin
            MDR_Out = 1'b1; G_RA = 1'b1; R_In = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
